// File: rtl/rvb_bextdep_issue.sv
// Issue stage for a bext/bdep/grev unit: decodes, holds one instruction, tracks credits
// and reorders nothing -- results leave through an in-order FIFO with registered head.
module rvb_bextdep_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned GREV  = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            bx_valid,
    input  logic            bx_ready,
    output logic [XLEN-1:0] bx_rs1,
    output logic [XLEN-1:0] bx_rs2,
    output logic            bx_insn3,
    output logic            bx_insn13,
    output logic            bx_insn14,
    input  logic            bx_dout_valid,
    input  logic [XLEN-1:0] bx_dout_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_illegal,
    output logic            err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       fn_ok, in_legal;

    always_comb begin
        opcode   = in_insn[6:0];
        funct3   = in_insn[14:12];
        funct7   = in_insn[31:25];
        fn_ok    = (funct3 == 3'b110 && (funct7 == 7'b0000100 || funct7 == 7'b0100100)) ||
                   (GREV != 0 && funct3 == 3'b101 && funct7 == 7'b0110100);
        in_legal = fn_ok && (opcode == 7'b0110011 || (XLEN == 64 && opcode == 7'b0111011));
    end

    logic            s_valid_q, s_legal_q, s_insn3_q, s_insn13_q, s_insn14_q;
    logic [XLEN-1:0] s_rs1_q, s_rs2_q;
    logic [4:0]      s_rd_q;
    logic            credit_ok, legal_leave, ill_leave, s_leaving, in_accept;

    logic [4:0]      tag_mem [DEPTH];
    logic [PW-1:0]   tag_wptr_q, tag_rptr_q;
    logic [CW-1:0]   tag_cnt_q;
    logic            tag_push, tag_pop;

    logic [4:0]      res_rd_mem   [DEPTH];
    logic [XLEN-1:0] res_data_mem [DEPTH];
    logic            res_ill_mem  [DEPTH];
    logic [PW-1:0]   res_wptr_q, res_rptr_q, res_rptr_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic            res_wr, res_we, res_pop;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_data;
    logic            w_ill;
    logic [CW:0]     occ;
    logic            err_q;

    // The tag FIFO count is exactly the number of requests still owed a result.
    assign occ         = {1'b0, tag_cnt_q} + {1'b0, res_cnt_q};
    assign credit_ok   = occ < (CW + 1)'(DEPTH);
    assign bx_valid    = s_valid_q && s_legal_q && credit_ok;
    assign legal_leave = bx_valid && bx_ready;
    assign ill_leave   = s_valid_q && !s_legal_q && (tag_cnt_q == '0) && credit_ok;
    assign s_leaving   = legal_leave || ill_leave;
    assign in_ready    = !s_valid_q || s_leaving;
    assign in_accept   = in_valid && in_ready;

    assign bx_rs1    = s_rs1_q;
    assign bx_rs2    = s_rs2_q;
    assign bx_insn3  = (XLEN == 64) ? s_insn3_q : 1'b0;
    assign bx_insn13 = s_insn13_q;
    assign bx_insn14 = s_insn14_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_valid_q  <= 1'b0;
            s_legal_q  <= 1'b0;
            s_insn3_q  <= 1'b0;
            s_insn13_q <= 1'b0;
            s_insn14_q <= 1'b0;
            s_rs1_q    <= '0;
            s_rs2_q    <= '0;
            s_rd_q     <= '0;
        end else if (in_accept) begin
            s_valid_q  <= 1'b1;
            s_legal_q  <= in_legal;
            s_insn3_q  <= in_insn[3];
            s_insn13_q <= in_insn[13];
            s_insn14_q <= in_insn[14];
            s_rs1_q    <= in_rs1;
            s_rs2_q    <= in_rs2;
            s_rd_q     <= in_rd;
        end else if (s_leaving) begin
            s_valid_q  <= 1'b0;
        end
    end

    assign tag_push = legal_leave;
    assign tag_pop  = bx_dout_valid && (tag_cnt_q != '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
            tag_cnt_q  <= '0;
        end else begin
            tag_wptr_q <= tag_wptr_q + PW'(tag_push);
            tag_rptr_q <= tag_rptr_q + PW'(tag_pop);
            tag_cnt_q  <= tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (tag_push) tag_mem[tag_wptr_q] <= s_rd_q;
    end

    // Unit results win the write port; the illegal-leave gate keeps the two apart.
    always_comb begin
        res_wr     = tag_pop || ill_leave;
        res_pop    = out_valid && out_ready;
        res_we     = res_wr && (res_cnt_q != Full || res_pop);
        w_rd       = tag_pop ? tag_mem[tag_rptr_q] : s_rd_q;
        w_data     = tag_pop ? bx_dout_rd : '0;
        w_ill      = !tag_pop;
        res_rptr_d = res_rptr_q + PW'(res_pop);
        res_cnt_d  = res_cnt_q + CW'(res_we) - CW'(res_pop);
    end

    always_ff @(posedge clock) begin
        if (res_we) begin
            res_rd_mem[res_wptr_q]   <= w_rd;
            res_data_mem[res_wptr_q] <= w_data;
            res_ill_mem[res_wptr_q]  <= w_ill;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            res_wptr_q  <= '0;
            res_rptr_q  <= '0;
            res_cnt_q   <= '0;
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_data    <= '0;
            out_illegal <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            res_wptr_q <= res_wptr_q + PW'(res_we);
            res_rptr_q <= res_rptr_d;
            res_cnt_q  <= res_cnt_d;
            out_valid  <= (res_cnt_d != '0);
            // Head register follows the next read slot, bypassing a same-cycle write into it.
            if (res_cnt_d != '0) begin
                if (res_we && res_wptr_q == res_rptr_d) begin
                    out_rd      <= w_rd;
                    out_data    <= w_data;
                    out_illegal <= w_ill;
                end else begin
                    out_rd      <= res_rd_mem[res_rptr_d];
                    out_data    <= res_data_mem[res_rptr_d];
                    out_illegal <= res_ill_mem[res_rptr_d];
                end
            end
            if ((bx_dout_valid && tag_cnt_q == '0) || (bx_dout_valid && ill_leave) ||
                (res_wr && res_cnt_q == Full && !res_pop)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

    logic unused_bits;
    assign unused_bits = ^{in_insn[24:15], in_insn[11:7], s_insn3_q};

endmodule

// File: doc/rvb_bextdep_issue.md
RVB_BEXTDEP_ISSUE -- requirements
Module: rvb_bextdep_issue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, datapath width; 32 or 64.
- GREV, 1, accept grev when 1.
- DEPTH, 4, result FIFO entries; power of two, at least 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when high with in_valid.
- in_insn  in  32  instruction word.
- in_rs1, in_rs2  in  XLEN  operands.
- in_rd  in  5  destination index.
- bx_valid  out  1  request to bext/bdep unit.
- bx_ready  in  1  unit accepts request.
- bx_rs1, bx_rs2  out  XLEN  operands to unit.
- bx_insn3, bx_insn13, bx_insn14  out  1  insn bits 3/13/14 to unit.
- bx_dout_valid  in  1  unit result pulse; the unit has no backpressure.
- bx_dout_rd  in  XLEN  unit result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_rd  out  5  destination index.
- out_data  out  XLEN  result value.
- out_illegal  out  1  entry came from an undecodable instruction.
- err  out  1  sticky protocol error.

Function
REQ-003 Decode legal ops:
- Opcode 0110011 with funct3 110: funct7 0000100 is bext; funct7 0100100 is bdep.
- Opcode 0110011 with funct3 101 and funct7 0110100 is grev, legal only when GREV=1.
- The same funct fields under opcode 0111011 are the W variants, legal only when XLEN=64.
- Everything else is illegal.
REQ-004 A single stage register S SHALL capture in_insn, in_rs1, in_rs2, in_rd and the legal flag on any cycle where in_valid and in_ready are both high.
REQ-005 in_ready SHALL equal (!S_valid || S_leaving), where S_leaving is combinational.
REQ-006 Counters:
- inflight: requests accepted by the unit whose result has not yet returned.
- occ: inflight + result-FIFO count.
- credit_ok: occ < DEPTH.
REQ-007 bx_valid SHALL equal S_valid && S_legal && credit_ok.
- bx_rs1, bx_rs2 and bx_insn* are driven directly from S.
- bx_insn3 is tied 0 when XLEN=32.
REQ-008 A legal S SHALL leave when bx_valid && bx_ready. On that cycle, S_rd is pushed onto an in-order tag FIFO of DEPTH entries.
REQ-009 An illegal S SHALL leave only when inflight==0 and credit_ok. On leaving, it writes {rd=S_rd, data=0, illegal=1} into the result FIFO that cycle, preserving program order.
REQ-010 On bx_dout_valid, the block SHALL pop the tag FIFO and write {rd=tag, data=bx_dout_rd, illegal=0} into the result FIFO.
- If an illegal write and a bx_dout_valid write coincide, the bx_dout_valid write goes first. This cannot happen while the REQ-009 gate holds, and err is set if it does.
REQ-011 Result FIFO behaviour:
- out_valid, out_rd, out_data and out_illegal are registered FIFO-head outputs.
- A write into an empty FIFO in cycle N gives out_valid high in cycle N+1.
- Pop occurs on out_valid && out_ready.
- Simultaneous push and pop SHALL be legal at any occupancy.
- Read and write pointers wrap modulo DEPTH.
REQ-012 Credit accounting SHALL guarantee the result FIFO never overflows, with out_ready held low indefinitely.
REQ-013 err SHALL set and hold until reset on any of:
- bx_dout_valid while the tag FIFO is empty.
- A result-FIFO write while the FIFO is full.
REQ-014 Minimum latency, assuming the unit latency is L and out_ready=1:
- Input accept in cycle N gives bx_valid in N+1.
- A result pulse in cycle M gives out_valid in M+1.
REQ-015 Ordering: out_* SHALL present results strictly in input acceptance order.

Reset
REQ-016 Asserting resetn low SHALL asynchronously clear the following, at any time including mid-operation, with all in-flight work discarded:
- S_valid, inflight, tag and result FIFO pointers, and err.
- out_valid, bx_valid, out_illegal and err outputs go to 0.
REQ-017 The first rising clock edge after resetn deassertion SHALL see in_ready=1. out_data and out_rd reset to 0.

Verification
REQ-018 The bench SHALL cover these scenarios (XLEN=32, DEPTH=4 unless noted):
- bext: insn funct7=0000100, funct3=110; rs1=0x12345678, rs2=0x0000FF00, rd=5. Expect out_rd=5, out_data=0x00000056, out_illegal=0.
- bdep: insn funct7=0100100, funct3=110; rs1=0x000000AB, rs2=0x0F0F0000. Expect out_data=0x0A0B0000.
- Illegal: insn 0x00000013 issued behind two legal ops. Expect the illegal entry emitted third with data 0 and out_illegal=1, and no bx_valid for it.
- Backpressure: out_ready=0 while 8 legal ops are offered. Expect exactly 4 bx handshakes, then in_ready=0 with S holding the fifth. Then out_ready=1: expect all 8 results in order, err=0.
- Reset mid-flight: pull resetn low with 3 ops in flight. Expect out_valid=0, bx_valid=0 and in_ready=1 after release. A stray bx_dout_valid afterwards sets err=1.
- GREV=0: a grev insn is reported illegal. XLEN=64: a W-variant bext is legal and drives bx_insn3=1.
